// File: rtl/iconn_unshuffle.sv
// iconn_unshuffle: registered inverse perfect-shuffle stage.
// Output port j takes input port rotl(j,1). Addresses, payloads and the
// occupancy mask are permuted together and held in one output register
// with a whole-vector valid/ready handshake.
// Optional feature: define ICONN_UNSHUFFLE_SKID_EN to add a one-entry skid
// register, which makes in_ready a pure flop output (capacity 2 beats).
module iconn_unshuffle #(
    parameter int NODE_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    localparam int PORT_NUM = 2 ** NODE_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NODE_ADDR_WIDTH-1:0] ain [0:PORT_NUM-1],
    input  logic [DATA_WIDTH-1:0]      din [0:PORT_NUM-1],
    input  logic [PORT_NUM-1:0]        din_valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NODE_ADDR_WIDTH-1:0] aout [0:PORT_NUM-1],
    output logic [DATA_WIDTH-1:0]      dout [0:PORT_NUM-1],
    output logic [PORT_NUM-1:0]        dout_valid
);

    // ---- stage p0: combinational permutation of the incoming vector ----
    logic [NODE_ADDR_WIDTH-1:0] perm_a_p0 [0:PORT_NUM-1];
    logic [DATA_WIDTH-1:0]      perm_d_p0 [0:PORT_NUM-1];
    logic [PORT_NUM-1:0]        perm_v_p0;

    // src(j) = 2j for the lower half, 2(j-PORT_NUM/2)+1 for the upper half,
    // i.e. a one-bit left rotate of j; this undoes the shuffle column.
    for (genvar j = 0; j < PORT_NUM; j++) begin : g_perm
        localparam int SRC = ((2 * j) % PORT_NUM) + (j / (PORT_NUM / 2));
        assign perm_a_p0[j] = ain[SRC];
        assign perm_d_p0[j] = din[SRC];
        assign perm_v_p0[j] = din_valid[SRC];
    end

    logic load_new;     // output register takes the freshly permuted beat

`ifdef ICONN_UNSHUFFLE_SKID_EN
    // ---- skid entry p1: holds an already-permuted beat while stalled ----
    logic [NODE_ADDR_WIDTH-1:0] sk_a_p1 [0:PORT_NUM-1];
    logic [DATA_WIDTH-1:0]      sk_d_p1 [0:PORT_NUM-1];
    logic [PORT_NUM-1:0]        sk_v_p1;
    logic                       sk_full;
    logic                       load_sk;      // accepted beat parks in skid
    logic                       load_from_sk; // skid entry moves to output
    logic                       accept;
    logic                       consume;

    // in_ready comes straight from the skid-occupancy flop, so out_ready
    // never reaches it combinationally.
    assign in_ready = !sk_full;
    assign accept   = in_valid && !sk_full;
    assign consume  = out_valid && out_ready;

    // Route each transfer: skid drains first, new beats go to the output
    // register when it is free or being consumed, otherwise to the skid.
    always_comb begin
        load_new     = 1'b0;
        load_sk      = 1'b0;
        load_from_sk = 1'b0;
        if (sk_full) begin
            load_from_sk = consume;
        end else if (accept) begin
            if (!out_valid || out_ready) begin
                load_new = 1'b1;
            end else begin
                load_sk = 1'b1;
            end
        end
    end

    // Control state: output valid and skid occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sk_full   <= 1'b0;
        end else begin
            if (load_new || load_from_sk) begin
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
            if (load_sk) begin
                sk_full <= 1'b1;
            end else if (load_from_sk) begin
                sk_full <= 1'b0;
            end
        end
    end

    // Skid payload; its contents are meaningless while sk_full is low.
    always_ff @(posedge clk) begin
        if (load_sk) begin
            sk_a_p1 <= perm_a_p0;
            sk_d_p1 <= perm_d_p0;
            sk_v_p1 <= perm_v_p0;
        end
    end

    // ---- stage p1: output register ----
    // Output register: load a new beat or promote the skid entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < PORT_NUM; j++) begin
                aout[j] <= '0;
                dout[j] <= '0;
            end
            dout_valid <= '0;
        end else if (load_new) begin
            aout       <= perm_a_p0;
            dout       <= perm_d_p0;
            dout_valid <= perm_v_p0;
        end else if (load_from_sk) begin
            aout       <= sk_a_p1;
            dout       <= sk_d_p1;
            dout_valid <= sk_v_p1;
        end
    end
`else
    // Single-entry stage: ready whenever the output register is empty or
    // is being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign load_new = in_valid && in_ready;

    // Control state: output valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (load_new) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // ---- stage p1: output register ----
    // Output register: load the permuted beat on every accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < PORT_NUM; j++) begin
                aout[j] <= '0;
                dout[j] <= '0;
            end
            dout_valid <= '0;
        end else if (load_new) begin
            aout       <= perm_a_p0;
            dout       <= perm_d_p0;
            dout_valid <= perm_v_p0;
        end
    end
`endif

endmodule

// File: doc/iconn_unshuffle.md
# iconn_unshuffle

Registered inverse perfect-shuffle (unshuffle) stage for the VP interconnect. It undoes the shuffle-exchange map: output port j takes input port rotl(j, 1), where rotl is a 1-bit left rotate over NODE_ADDR_WIDTH bits. The stage sits on the return and egress side of the shuffle network, so a shuffle followed by this block is the identity permutation. It adds one register stage with a whole-vector valid/ready handshake, which lets it break long combinational paths between network columns.

## Interface
- NODE_ADDR_WIDTH, 5, port-address width; PORT_NUM = 2**NODE_ADDR_WIDTH
- DATA_WIDTH, 64, per-port payload width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input vector beat is valid
- in_ready  out  1  stage can accept a beat this cycle
- ain  in  NODE_ADDR_WIDTH x PORT_NUM  per-port destination address, unpacked [0:PORT_NUM-1]
- din  in  DATA_WIDTH x PORT_NUM  per-port payload, unpacked [0:PORT_NUM-1]
- din_valid  in  PORT_NUM  per-port occupancy mask
- out_valid  out  1  output beat is valid
- out_ready  in  1  downstream accepts the beat
- aout  out  NODE_ADDR_WIDTH x PORT_NUM  permuted addresses
- dout  out  DATA_WIDTH x PORT_NUM  permuted payloads
- dout_valid  out  PORT_NUM  permuted occupancy mask

## Operation
- Permutation: src(j) = {j[NODE_ADDR_WIDTH-2:0], j[NODE_ADDR_WIDTH-1]}.
  - Equivalently, src(j) = 2j for j < PORT_NUM/2, and src(j) = 2(j-PORT_NUM/2)+1 otherwise.
  - aout[j], dout[j] and dout_valid[j] all take the same src(j).
- ain contents pass through unmodified. No address rewrite and no exchange are performed.
- Beat transfer:
  - An input beat is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
- A beat with din_valid == 0 is still a beat. It is transferred and counted like any other beat.
- Main output register (OR): holds the permuted vector and drives out_valid.
- OR updates on a cycle with an accepted input and (out_valid == 0 or out_ready == 1).
- Simultaneous accept and consume: OR loads the new beat, and out_valid stays 1.
- Consume with no accept: out_valid drops to 0 on the next edge.
- In-flight data is never dropped, duplicated or reordered.

## Timing
- Latency: a beat accepted at edge k appears on the outputs after edge k (1 cycle). Throughput is 1 beat per cycle when out_ready is held at 1.
- Reset values (rst_n sampled low at an edge):
  - out_valid = 0, dout_valid = 0, aout = 0, dout = 0.
  - The skid buffer is emptied.
  - in_ready after reset: 1 in both build variants.
- Reset mid-operation: all buffered beats are discarded, and nothing is emitted after reset.
- in_valid during reset is ignored.
- out_ready asserted while out_valid == 0 has no effect.
- Inputs may change freely while in_valid == 0.
- Once out_valid is 1, aout, dout and dout_valid stay stable until consumed.

## Configuration
- ICONN_UNSHUFFLE_SKID_EN undefined:
  - Single-entry stage, with in_ready = !out_valid || out_ready (combinational from out_ready).
  - Capacity is 1 beat.
- ICONN_UNSHUFFLE_SKID_EN defined:
  - Adds a one-entry skid register (SK), which holds the already-permuted vector.
  - in_ready is driven directly from a flop and equals !sk_full. There is no combinational path from out_ready to in_ready.
  - Capacity is 2 beats.
  - SK fill: on an accept while out_valid && !out_ready, the beat goes to SK and sk_full becomes 1. This makes in_ready 0 on the next cycle.
  - SK drain: on a consume while sk_full, SK moves to OR and sk_full becomes 0.
  - Ordering stays FIFO. Throughput is 1 beat per cycle when out_ready = 1.

## Test plan
Parameters: NODE_ADDR_WIDTH = 5, DATA_WIDTH = 64.
- Basic permutation: din[i] = i, ain[i] = i, one beat, out_ready = 1. The output must show dout[1] = 2, dout[15] = 30, dout[16] = 1, dout[31] = 31, and aout[j] = dout[j].
  - out_valid must be 1 exactly one cycle after the accept.
- Mask permutation: din_valid = 32'h0000_0002 must produce dout_valid = 32'h0001_0000. din_valid = 32'h8000_0001 must produce 32'h8000_0001.
- Round trip with iconn_shuffle: 1000 random beats through iconn_shuffle then this block. Outputs must equal the inputs bit-exact and in order.
- Backpressure: stream 8 beats (din[0] = 0..7) while out_ready toggles as a random 50% pattern. All 8 beats must arrive once, in order, and the outputs must not change while stalled.
  - Skid build: in_ready must fall only after the second beat is held, and in_ready must not track out_ready in the same cycle.
- Reset mid-stream: with 2 beats buffered (skid build), drive rst_n = 0 for 1 cycle.
  - The next cycle must show out_valid = 0, dout_valid = 0 and in_ready = 1.
  - No stale beat may appear after reset.
